// File: rtl/spi_resp_framer.sv
// spi_resp_framer: frames a CCU response (header + AXI4-Stream payload) into
// SYNC, CMD, LEN, payload[LEN], CHECKSUM for the SPI slave transmitter.
// Optional build macro SPI_RESP_FRAMER_CRC8_EN selects a CRC-8 (poly 0x07)
// checksum; otherwise the checksum is the XOR of CMD, LEN and payload/pad.
module spi_resp_framer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       axi_aclk,
  input  logic       axi_aresetn,
  input  logic       hdr_valid,
  output logic       hdr_ready,
  input  logic [7:0] hdr_cmd,
  input  logic [7:0] hdr_len,
  input  logic [7:0] axis_sdata,
  input  logic       axis_svalid,
  output logic       axis_sready,
  input  logic       axis_slast,
  output logic [7:0] axis_rdata,
  output logic       axis_rvalid,
  input  logic       axis_rready,
  output logic       axis_rlast,
  output logic       err_len
);

  localparam int unsigned W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_CMD, S_LEN, S_PAYLOAD, S_PAD, S_CSUM
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_cmd;
  logic [W-1:0] r_len;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_csum;
  logic [W-1:0] r_rdata;
  logic         r_rvalid;
  logic         r_rlast;
  logic         r_hdr_ready;
  logic         r_err_len;

  logic         w_in_pay;
  logic         w_r_hs;
  logic         w_hdr_hs;
  logic         w_cnt_last;
  logic [W-1:0] w_csum_nxt;

  // Fold one byte into the running checksum.
  function automatic logic [W-1:0] f_fold(input logic [W-1:0] i_acc, input logic [W-1:0] i_byte);
`ifdef SPI_RESP_FRAMER_CRC8_EN
    logic [W-1:0] v;
    v = i_acc ^ i_byte;
    for (int b = 0; b < 8; b++) begin
      v = v[7] ? ((v << 1) ^ 8'h07) : (v << 1);
    end
    return v;
`else
    return i_acc ^ i_byte;
`endif
  endfunction

  assign w_in_pay   = (r_state == S_PAYLOAD);
  assign w_r_hs     = axis_rvalid && axis_rready;
  assign w_hdr_hs   = hdr_valid && r_hdr_ready;
  assign w_cnt_last = (r_cnt == W'(r_len - 8'd1));
  // The byte on the output bus is always the one being folded on a handshake.
  assign w_csum_nxt = f_fold(r_csum, axis_rdata);

  // Payload passes straight through; every other byte comes from registers.
  assign axis_rdata  = w_in_pay ? axis_sdata  : r_rdata;
  assign axis_rvalid = w_in_pay ? axis_svalid : r_rvalid;
  assign axis_sready = w_in_pay && axis_rready;
  assign axis_rlast  = r_rlast;
  assign hdr_ready   = r_hdr_ready;
  assign err_len     = r_err_len;

  // Frame sequencer with registered outputs.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_csum      <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_hdr_ready <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_err_len <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_hdr_ready <= 1'b1;
          r_rvalid    <= 1'b0;
          r_rlast     <= 1'b0;
          if (w_hdr_hs) begin
            r_cmd       <= hdr_cmd;
            r_len       <= hdr_len;
            r_cnt       <= '0;
            r_csum      <= '0;
            r_hdr_ready <= 1'b0;
            r_rvalid    <= 1'b1;
            r_rdata     <= SYNC_BYTE;
            r_state     <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (w_r_hs) begin
            r_rdata <= r_cmd;
            r_state <= S_CMD;
          end
        end
        S_CMD: begin
          if (w_r_hs) begin
            r_csum  <= w_csum_nxt;
            r_rdata <= r_len;
            r_state <= S_LEN;
          end
        end
        S_LEN: begin
          if (w_r_hs) begin
            r_csum <= w_csum_nxt;
            if (r_len != '0) begin
              r_state <= S_PAYLOAD;
            end else begin
              r_rdata <= w_csum_nxt;
              r_rlast <= 1'b1;
              r_state <= S_CSUM;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_r_hs) begin
            r_csum <= w_csum_nxt;
            r_cnt  <= W'(r_cnt + 8'd1);
            if (w_cnt_last) begin
              // Surplus payload beyond len stays upstream for the next frame.
              r_err_len <= !axis_slast;
              r_rdata   <= w_csum_nxt;
              r_rlast   <= 1'b1;
              r_state   <= S_CSUM;
            end else if (axis_slast) begin
              r_err_len <= 1'b1;
              r_rdata   <= '0;
              r_state   <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (w_r_hs) begin
            r_csum <= w_csum_nxt;
            r_cnt  <= W'(r_cnt + 8'd1);
            if (w_cnt_last) begin
              r_rdata <= w_csum_nxt;
              r_rlast <= 1'b1;
              r_state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (w_r_hs) begin
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rdata     <= '0;
            r_hdr_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_resp_framer.sv
// Bench for spi_resp_framer: random header/payload/backpressure traffic
// checked every cycle against a frame-level model built from queues.
module tb_spi_resp_framer;

  localparam logic [7:0] SYNC = 8'hA5;

  logic       axi_aclk = 1'b0;
  logic       axi_aresetn;
  logic       hdr_valid;
  logic       hdr_ready;
  logic [7:0] hdr_cmd;
  logic [7:0] hdr_len;
  logic [7:0] axis_sdata;
  logic       axis_svalid;
  logic       axis_sready;
  logic       axis_slast;
  logic [7:0] axis_rdata;
  logic       axis_rvalid;
  logic       axis_rready;
  logic       axis_rlast;
  logic       err_len;

  always #5 axi_aclk = ~axi_aclk;

  spi_resp_framer dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .hdr_valid   (hdr_valid),
    .hdr_ready   (hdr_ready),
    .hdr_cmd     (hdr_cmd),
    .hdr_len     (hdr_len),
    .axis_sdata  (axis_sdata),
    .axis_svalid (axis_svalid),
    .axis_sready (axis_sready),
    .axis_slast  (axis_slast),
    .axis_rdata  (axis_rdata),
    .axis_rvalid (axis_rvalid),
    .axis_rready (axis_rready),
    .axis_rlast  (axis_rlast),
    .err_len     (err_len)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Source stream (driver copy and model copy), headers, expected output bytes.
  logic [8:0]  s_q[$];
  logic [8:0]  m_q[$];
  logic [15:0] h_q[$];
  logic [9:0]  e_q[$];   // {is_payload, last, data}
  logic [9:0]  f_log[$];
  int          ee_q[$];
  int          m_err;

  logic h_acc = 1'b0;
  logic s_acc = 1'b0;
  bit   mon_en = 1'b0;
  int   rr_mode = 0;
  bit   src_rand = 1'b0;
  bit   stall_arm = 1'b0;
  int   stall_left = 0;
  int   stall_seen = 0;
  int   in_frame = 0;
  int   err_cnt = 0;
  logic p_stall = 1'b0;
  logic [7:0] p_rdata = 8'h00;
  logic p_rlast = 1'b0;
  logic [9:0] mon_hd;
  logic mon_pay;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fold(input logic [7:0] acc, input logic [7:0] d);
`ifdef SPI_RESP_FRAMER_CRC8_EN
    logic [7:0] c;
    logic fb;
    c = acc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
`else
    return acc ^ d;
`endif
  endfunction

  task automatic add_byte(input logic last, input logic [7:0] d);
    s_q.push_back({last, d});
    m_q.push_back({last, d});
  endtask

  task automatic add_chunk(input int n);
    for (int i = 0; i < n; i++) add_byte(i == n - 1, 8'($urandom));
  endtask

  // Frame model: take up to len bytes from the stream, stopping at slast; pad the rest.
  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] len);
    logic [7:0] ck;
    logic [8:0] e;
    int cnt;
    bit done;
    f_log.delete();
    ck = 8'h00;
    f_log.push_back({2'b00, SYNC});
    f_log.push_back({2'b00, cmd});  ck = fold(ck, cmd);
    f_log.push_back({2'b00, len});  ck = fold(ck, len);
    cnt = 0; done = 1'b0; m_err = 0;
    while (cnt < int'(len) && !done) begin
      if (m_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL model_underrun: actual 0 required %0d bytes", int'(len) - cnt);
        done = 1'b1;
      end else begin
        e = m_q.pop_front();
        f_log.push_back({1'b1, 1'b0, e[7:0]});
        ck = fold(ck, e[7:0]);
        cnt++;
        if (e[8]) begin
          done = 1'b1;
          if (cnt < int'(len)) m_err = 1;
        end else if (cnt == int'(len)) begin
          m_err = 1;
        end
      end
    end
    while (cnt < int'(len)) begin
      f_log.push_back({2'b00, 8'h00});
      ck = fold(ck, 8'h00);
      cnt++;
    end
    f_log.push_back({2'b01, ck});
    foreach (f_log[i]) e_q.push_back(f_log[i]);
    ee_q.push_back(m_err);
    h_q.push_back({cmd, len});
  endtask

  // Pin the model output of the last frame against hand-computed bytes.
  task automatic pin(input string nm, input int n, input logic [63:0] bytes, input int err);
    chk({nm, "_len"}, 32'(f_log.size()), 32'(n));
    for (int i = 0; i < n && i < f_log.size(); i++)
      chk({nm, "_byte"}, 32'(f_log[i][7:0]), 32'(bytes[8*(n-1-i) +: 8]));
    if (f_log.size() > 0) chk({nm, "_last"}, 32'(f_log[f_log.size()-1][8]), 32'd1);
    chk({nm, "_err"}, 32'(m_err), 32'(err));
  endtask

  task automatic drain(input int max);
    int c;
    c = 0;
    while ((e_q.size() != 0 || h_q.size() != 0) && c < max) begin
      @(posedge axi_aclk);
      c++;
    end
    chk("drain_remaining", 32'(e_q.size()), 32'd0);
    repeat (3) @(posedge axi_aclk);
  endtask

  // Compare process: checks every output on every cycle against the model queue head.
  always @(negedge axi_aclk) begin
    if (mon_en && axi_aresetn) begin
      h_acc = hdr_valid && hdr_ready;
      s_acc = axis_svalid && axis_sready;
      mon_hd = (e_q.size() != 0) ? e_q[0] : 10'h000;
      mon_pay = (in_frame > 0) && mon_hd[9];
      if (in_frame > 0) chk("hdr_ready_busy", 32'(hdr_ready), 32'd0);
      if (!mon_pay) begin
        chk("sready_low", 32'(axis_sready), 32'd0);
      end else begin
        chk("sready_pass", 32'(axis_sready), 32'(axis_rready));
        chk("rvalid_pass", 32'(axis_rvalid), 32'(axis_svalid));
        if (axis_svalid) chk("rdata_pass", 32'(axis_rdata), 32'(axis_sdata));
      end
      if (in_frame == 0) begin
        chk("rvalid_idle", 32'(axis_rvalid), 32'd0);
      end else if (!mon_pay) begin
        chk("rvalid_frame", 32'(axis_rvalid), 32'd1);
        chk("rdata_frame", 32'(axis_rdata), 32'(mon_hd[7:0]));
        chk("rlast_frame", 32'(axis_rlast), 32'(mon_hd[8]));
      end
      if (p_stall) begin
        chk("hold_valid", 32'(axis_rvalid), 32'd1);
        chk("hold_data", 32'(axis_rdata), 32'(p_rdata));
        chk("hold_last", 32'(axis_rlast), 32'(p_rlast));
      end
      if (in_frame > 0 && !mon_pay && axis_rvalid && !axis_rready && axis_rdata == 8'h12)
        stall_seen++;
      if (err_len) err_cnt++;
      if (axis_rvalid && axis_rready) begin
        if (e_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_byte: actual %0h required none", axis_rdata);
        end else begin
          mon_hd = e_q.pop_front();
          chk("hs_data", 32'(axis_rdata), 32'(mon_hd[7:0]));
          chk("hs_last", 32'(axis_rlast), 32'(mon_hd[8]));
          if (mon_hd[8]) begin
            chk("err_len_count", 32'(err_cnt), 32'((ee_q.size() != 0) ? ee_q.pop_front() : 0));
            err_cnt = 0;
            in_frame--;
          end
        end
      end
      if (h_acc) in_frame++;
      p_stall = axis_rvalid && !axis_rready;
      p_rdata = axis_rdata;
      p_rlast = axis_rlast;
    end else begin
      h_acc = 1'b0;
      s_acc = 1'b0;
      p_stall = 1'b0;
    end
  end

  // Driver: owns all DUT inputs except reset; updates #1 after each rising edge.
  initial begin
    logic keep;
    hdr_valid = 1'b0; hdr_cmd = 8'h00; hdr_len = 8'h00;
    axis_svalid = 1'b0; axis_sdata = 8'h00; axis_slast = 1'b0;
    axis_rready = 1'b0;
    forever begin
      @(posedge axi_aclk);
      #1;
      if (h_acc && h_q.size() != 0) void'(h_q.pop_front());
      keep = axis_svalid && !s_acc;
      if (s_acc && s_q.size() != 0) void'(s_q.pop_front());
      hdr_valid = (h_q.size() != 0);
      if (h_q.size() != 0) {hdr_cmd, hdr_len} = h_q[0];
      if (s_q.size() == 0) axis_svalid = 1'b0;
      else if (keep) axis_svalid = 1'b1;
      else axis_svalid = src_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (s_q.size() != 0) {axis_slast, axis_sdata} = s_q[0];
      if (stall_left > 0) begin
        axis_rready = 1'b0;
        stall_left--;
      end else if (stall_arm && axis_rvalid && axis_rdata == 8'h12) begin
        stall_arm = 1'b0;
        stall_left = 4;
        axis_rready = 1'b0;
      end else begin
        case (rr_mode)
          0:       axis_rready = 1'b1;
          1:       axis_rready = ~axis_rready;
          default: axis_rready = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  initial begin
    int lenv, n, sel, got;
    axi_aresetn = 1'b0;
    #2;
    chk("rst_hdr_ready", 32'(hdr_ready), 32'd0);
    chk("rst_rvalid", 32'(axis_rvalid), 32'd0);
    chk("rst_sready", 32'(axis_sready), 32'd0);
    chk("rst_rlast", 32'(axis_rlast), 32'd0);
    chk("rst_rdata", 32'(axis_rdata), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    repeat (3) @(posedge axi_aclk);
    #3 axi_aresetn = 1'b1;
    mon_en = 1'b1;
    @(posedge axi_aclk);
    #2 chk("idle_hdr_ready", 32'(hdr_ready), 32'd1);

    // Directed frames with rready held high.
    rr_mode = 0; src_rand = 1'b0;
    add_byte(1'b0, 8'h01); add_byte(1'b0, 8'h02); add_byte(1'b1, 8'h03);
    model_frame(8'h12, 8'd3);
`ifndef SPI_RESP_FRAMER_CRC8_EN
    pin("tp_len3", 7, 64'hA5_12_03_01_02_03_11, 0);
`endif
    model_frame(8'h40, 8'd0);
`ifndef SPI_RESP_FRAMER_CRC8_EN
    pin("tp_len0", 4, 64'hA5_40_00_40, 0);
`endif
    add_byte(1'b0, 8'hAA); add_byte(1'b1, 8'hBB);
    model_frame(8'h20, 8'd4);
`ifndef SPI_RESP_FRAMER_CRC8_EN
    pin("tp_pad", 8, 64'hA5_20_04_AA_BB_00_00_35, 1);
`endif
    model_frame(8'h01, 8'd0);
`ifdef SPI_RESP_FRAMER_CRC8_EN
    pin("tp_crc", 4, 64'hA5_01_00_15, 0);
`else
    pin("tp_cmd01", 4, 64'hA5_01_00_01, 0);
`endif
    drain(3000);

    // Toggling rready plus a 5-cycle stall on CMD, with a second header queued.
    rr_mode = 1; stall_seen = 0; stall_arm = 1'b1;
    add_byte(1'b0, 8'h01); add_byte(1'b0, 8'h02); add_byte(1'b1, 8'h03);
    model_frame(8'h12, 8'd3);
    add_byte(1'b0, 8'h9C); add_byte(1'b1, 8'hE1);
    model_frame(8'h55, 8'd2);
    drain(3000);
    chk("cmd_stall_cycles", 32'(stall_seen >= 5), 32'd1);

    // Random frames: exact, short and long payloads with random valid/ready.
    rr_mode = 2; src_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      sel = int'($urandom_range(0, 11));
      lenv = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 255 : int'($urandom_range(2, 16));
      if (lenv == 0) n = int'($urandom_range(1, 3));
      else begin
        sel = int'($urandom_range(0, 5));
        if (sel == 0 && lenv > 1) n = int'($urandom_range(1, lenv - 1));
        else if (sel == 1) n = lenv + int'($urandom_range(1, 3));
        else n = lenv;
      end
      add_chunk(n);
      model_frame(8'($urandom), 8'(lenv));
    end
    drain(40000);

    // Reset in the middle of a payload, then a fresh frame.
    rr_mode = 0; src_rand = 1'b0;
    s_q.delete(); m_q.delete();
    add_chunk(10);
    model_frame(8'h33, 8'd10);
    got = 0;
    for (int c = 0; c < 200 && got < 3; c++) begin
      @(negedge axi_aclk);
      #1 if (s_acc) got++;
    end
    chk("reach_payload", 32'(got), 32'd3);
    @(posedge axi_aclk);
    #3 axi_aresetn = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(axis_rvalid), 32'd0);
    chk("midrst_sready", 32'(axis_sready), 32'd0);
    chk("midrst_rlast", 32'(axis_rlast), 32'd0);
    chk("midrst_rdata", 32'(axis_rdata), 32'd0);
    chk("midrst_err_len", 32'(err_len), 32'd0);
    chk("midrst_hdr_ready", 32'(hdr_ready), 32'd0);
    s_q.delete(); m_q.delete(); h_q.delete(); e_q.delete(); ee_q.delete();
    in_frame = 0; err_cnt = 0;
    repeat (2) @(posedge axi_aclk);
    #3 axi_aresetn = 1'b1;
    mon_en = 1'b1;
    add_byte(1'b1, 8'h77);
    model_frame(8'h5A, 8'd1);
`ifndef SPI_RESP_FRAMER_CRC8_EN
    pin("post_rst", 5, 64'hA5_5A_01_77_2C, 0);
`endif
    drain(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_resp_framer.md
Name: spi_resp_framer

Overview:
Upstream neighbour of the SPI slave transmitter. Takes a CCU response, made of a header handshake (command, payload length) plus an AXI4-Stream payload. Emits a framed byte stream on an AXI4-Stream master that connects directly to the transmitter's axis_r* inputs. Frame format: SYNC, CMD, LEN, LEN payload bytes, CHECKSUM, with axis_rlast on CHECKSUM.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame (not included in checksum)

Ports:
axi_aclk  input  1  system clock
axi_aresetn  input  1  asynchronous active-low reset
hdr_valid  input  1  response header valid
hdr_ready  output  1  header accepted when hdr_valid && hdr_ready
hdr_cmd  input  8  command/status byte
hdr_len  input  8  payload byte count, 0..255
axis_sdata  input  8  payload byte from CCU
axis_svalid  input  1  payload valid
axis_sready  output  1  payload ready
axis_slast  input  1  last payload byte marker
axis_rdata  output  8  framed byte to SPI transmitter
axis_rvalid  output  1  framed byte valid
axis_rready  input  1  SPI transmitter ready
axis_rlast  output  1  high on CHECKSUM byte only
err_len  output  1  one-cycle pulse on payload length/slast mismatch

Behaviour:
- Reset (async assert, sync deassert by the upstream synchroniser):
  - State IDLE.
  - hdr_ready=0 for the cycle of reset, 1 in IDLE afterwards.
  - axis_rvalid=0, axis_sready=0, axis_rlast=0, axis_rdata=0, err_len=0.
  - Counters, checksum and header registers cleared.
  - Reset mid-frame abandons the partial frame; nothing is resumed.
- States: IDLE, SYNC, CMD, LEN, PAYLOAD, PAD, CSUM.
- IDLE:
  - hdr_ready=1.
  - On header handshake at cycle T: latch cmd/len, clear byte counter, checksum <= 0, go SYNC.
  - axis_rvalid=1 with SYNC_BYTE at T+1.
- SYNC/CMD/LEN:
  - axis_rvalid=1, data = SYNC_BYTE / cmd / len respectively.
  - Advance only on axis_rvalid && axis_rready.
  - CMD and LEN are folded into the checksum on their handshake.
  - LEN goes to PAYLOAD if len!=0, else to CSUM.
- PAYLOAD is zero-latency pass-through:
  - axis_rdata = axis_sdata, axis_rvalid = axis_svalid, axis_sready = axis_rready.
  - Each accepted byte is folded into the checksum and increments a count (8-bit).
- PAYLOAD exit rules:
  - Byte with count==len-1 accepted: go CSUM. If axis_slast=0 on it, pulse err_len; later payload bytes are left for the next frame.
  - axis_slast=1 accepted with count<len-1: pulse err_len, go PAD.
- PAD:
  - axis_sready=0; emit 0x00 bytes (axis_rvalid=1) until len total payload bytes have been sent.
  - Pad bytes are folded into the checksum (no XOR effect); then go CSUM.
- CSUM:
  - axis_rvalid=1, axis_rdata = checksum, axis_rlast=1.
  - On handshake go IDLE; the next header can be accepted the following cycle.
- Checksum default: 8-bit XOR of CMD, LEN and all payload/pad bytes.
- Handshake rules:
  - Outside PAYLOAD, axis_rvalid/rdata/rlast hold stable while axis_rready=0.
  - axis_sready=0 in every state except PAYLOAD.
  - hdr_ready=0 outside IDLE.
- err_len: registered, exactly one cycle per offending event, never during reset.
- Count wrap: len is at most 255, so the count never exceeds 254 in PAYLOAD; no wrap case.

Optional Feature:
SPI_RESP_FRAMER_CRC8_EN:
- Defined: checksum is CRC-8, polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR, over CMD, LEN and payload/pad bytes. Computed bytewise in one cycle per accepted byte.
- Undefined: XOR checksum as above.
- Frame format and timing are identical in both cases.

Test Plan:
- Header cmd=0x12, len=3; payload 01 02 03 with slast on 03; rready=1 -> stream A5 12 03 01 02 03 11, rlast only on 0x11, err_len=0.
- Header cmd=0x40, len=0 -> A5 40 00 40, rlast on 0x40, axis_sready never high.
- Header cmd=0x20, len=4; payload AA BB with slast on BB -> A5 20 04 AA BB 00 00 35, one err_len pulse, axis_sready low during pad.
- Frame 1 with rready toggling 1010… plus a 5-cycle rready=0 stall on CMD -> axis_rdata=0x12 and rvalid held through the stall; byte order unchanged; header 2 accepted only after the CSUM handshake.
- Assert axi_aresetn=0 mid-PAYLOAD -> outputs zero immediately (asynchronous); after release, a fresh header yields a fresh frame starting with A5.
- With SPI_RESP_FRAMER_CRC8_EN, cmd=0x01, len=0 -> A5 01 00 15.
